opcol_issue_arbiter: RTL
========================

OPCOL_ISSUE_ARBITER -- requirements
Module: opcol_issue_arbiter

Interface
REQ-001 SHALL have parameter NUM_COL, default 4, meaning the number of operand-collector units competing for the execute pipeline register.
REQ-002 SHALL have parameter BUSY_W, default 4, meaning the width of the FU occupancy counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port colReq_i, input, NUM_COL bits: collector i holds a complete operand packet.
REQ-006 SHALL have port colLong_i, input, NUM_COL bits: collector i's packet occupies the FU for multiple cycles.
REQ-007 SHALL have port colLat_i, input, NUM_COL*BUSY_W bits: occupancy cycles for collector i, in slice [i*BUSY_W +: BUSY_W].
REQ-008 SHALL have port exStall_i, input, 1 bit: execute-stage stall.
REQ-009 SHALL have port colGrant_o, output, NUM_COL bits: one-hot grant, registered.
REQ-010 SHALL have port colSel_o, output, clog2(NUM_COL) bits: binary index of the granted collector, registered; it drives the packet mux.
REQ-011 SHALL have port issueValid_o, output, 1 bit: drives fuPacketValid_i of the execute pipeline register.
REQ-012 SHALL have port pipeStall_o, output, 1 bit: drives stall_i of the execute pipeline register.
REQ-013 SHALL have port busy_o, output, 1 bit: FU occupancy in progress.

Function
REQ-014 SHALL implement a two-state FSM, READY and BUSY.
REQ-015 In READY, when exStall_i=0 and any request is eligible, SHALL grant exactly one collector per cycle.
- Timing: request sampled at edge N; colGrant_o/colSel_o/issueValid_o high for cycle N+1 only.
REQ-016 SHALL arbitrate round-robin: search starts at (last granted index + 1) mod NUM_COL.
REQ-017 SHALL update the round-robin pointer only on a grant.
REQ-018 SHALL exclude the currently granted collector from arbitration while its grant is high; the collector drops colReq_i the cycle after the grant.
REQ-019 When the granted packet has colLong_i=1, SHALL load the counter with colLat_i and enter BUSY.
- colLat_i=0 SHALL be treated as 1.
REQ-020 In BUSY:
- SHALL decrement the counter each cycle that exStall_i=0.
- SHALL make no grants.
- SHALL hold busy_o=1.
- SHALL return to READY in the cycle after the counter reaches 0; a grant is possible at that edge.
REQ-021 While exStall_i=1, SHALL freeze the counter, pointer and state, issue no new grant, and drive issueValid_o=0.
REQ-022 SHALL drive pipeStall_o = exStall_i combinationally, so the register holds its contents.
REQ-023 If exStall_i and a request rise at the same edge, SHALL make no grant; the grant follows the first unstalled edge.
REQ-024 SHALL keep colSel_o and colGrant_o consistent: colGrant_o = 1 << colSel_o when issueValid_o=1, else colGrant_o = 0.
REQ-025 With no requests, SHALL hold issueValid_o=0 and leave the pointer unchanged.

Reset
REQ-026 On reset assertion, SHALL immediately clear colGrant_o, colSel_o, issueValid_o, busy_o and the counter, set the pointer to NUM_COL-1 (collector 0 first), and set state READY.
REQ-027 Reset mid-BUSY SHALL abort the occupancy; the first grant is possible at the first edge after reset release.

Structure
REQ-028 SHALL place NUM_COL, BUSY_W and the READY/BUSY state encoding in a shared package, opcol_pkg.
REQ-029 SHALL implement the combinational rotate-priority-select as sub-module rr_pick, which returns a one-hot vector and an index.

Verification
REQ-030 Single request: reset, then colReq_i=4'b0100 -> colGrant_o=4'b0100, colSel_o=2, issueValid_o=1 for one cycle, then 0.
REQ-031 Fairness: colReq_i=4'b1111 held 8 cycles (each collector re-requests) -> grant order 0,1,2,3,0,1,2,3.
REQ-032 Long op: grant collector 1 with colLong_i[1]=1 and lat=3 while collector 2 requests -> busy_o high 3 cycles; collector 2 is granted on the 4th cycle after collector 1's grant.
REQ-033 Stall: exStall_i=1 for 5 cycles during BUSY with counter=2 -> counter holds at 2, pipeStall_o=1, no grants; after release, 2 more busy cycles.
REQ-034 Async reset: assert reset mid-cycle during BUSY -> busy_o=0 and colGrant_o=0 before the next clk edge; after release, collector 0 wins with colReq_i=4'b1111.
REQ-035 Zero latency: colLong_i=1 with colLat_i=0 -> exactly 1 busy cycle.

Source files
------------

// File: rtl/opcol_pkg.sv
// Shared constants and FSM encoding for the operand-collector issue arbiter.
package opcol_pkg;
    localparam int NUM_COL = 4;
    localparam int BUSY_W  = 4;

    typedef enum logic {
        ST_READY = 1'b0,
        ST_BUSY  = 1'b1
    } arb_state_e;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/opcol_issue_arbiter_rr_pick.sv
// Rotating-priority select: first set bit of req searching upward from last+1, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          any,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);
    always_comb begin
        int cand;
        cand   = 0;
        any    = 1'b0;
        onehot = '0;
        idx    = '0;
        for (int off = 1; off <= N; off++) begin
            cand = (int'(last) + off) % N;
            if (!any && req[cand]) begin
                any          = 1'b1;
                onehot[cand] = 1'b1;
                idx          = IW'(cand);
            end
        end
    end
endmodule

// File: rtl/opcol_issue_arbiter.sv
// Round-robin issue arbiter between operand collectors and the execute pipeline register,
// with an FU occupancy counter that blocks issue for multi-cycle operations.
module opcol_issue_arbiter
    import opcol_pkg::*;
#(
    parameter int  NUM_COL = opcol_pkg::NUM_COL,
    parameter int  BUSY_W  = opcol_pkg::BUSY_W,
    localparam int SEL_W   = sel_width(NUM_COL)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_COL-1:0]        colReq_i,
    input  logic [NUM_COL-1:0]        colLong_i,
    input  logic [NUM_COL*BUSY_W-1:0] colLat_i,
    input  logic                      exStall_i,
    output logic [NUM_COL-1:0]        colGrant_o,
    output logic [SEL_W-1:0]          colSel_o,
    output logic                      issueValid_o,
    output logic                      pipeStall_o,
    output logic                      busy_o
);
    arb_state_e         state_q, state_d;
    logic [BUSY_W-1:0]  cnt_q, cnt_d, pick_lat, lat_eff;
    logic [SEL_W-1:0]   ptr_q, sel_q, pick_idx;
    logic               vld_q, pick_any, pick_long, can_issue, do_grant;
    logic [NUM_COL-1:0] excl, elig, pick_oh;

    // The collector holding the live grant still asserts its request this cycle.
    assign excl = vld_q ? (NUM_COL'(1) << sel_q) : '0;
    assign elig = colReq_i & ~excl;

    rr_pick #(.N(NUM_COL), .IW(SEL_W)) u_pick (
        .req    (elig),
        .last   (ptr_q),
        .any    (pick_any),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    assign pick_long = |(colLong_i & pick_oh);
    assign pick_lat  = colLat_i[int'(pick_idx)*BUSY_W +: BUSY_W];
    assign lat_eff   = (pick_lat == '0) ? BUSY_W'(1) : pick_lat;
    // A drained BUSY counter may issue on the same edge it returns to READY.
    assign can_issue = !exStall_i && ((state_q == ST_READY) || (cnt_q == '0));
    assign do_grant  = can_issue && pick_any;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!exStall_i) begin
            case (state_q)
                ST_READY: begin
                    if (do_grant && pick_long) begin
                        state_d = ST_BUSY;
                        cnt_d   = lat_eff;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q != '0)
                        cnt_d = cnt_q - 1'b1;
                    else if (do_grant && pick_long)
                        cnt_d = lat_eff;
                    else
                        state_d = ST_READY;
                end
                default: state_d = ST_READY;
            endcase
        end
    end

    // Grant registers freeze under stall so a stalled grant is re-presented afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= 1'b0;
            sel_q <= '0;
            ptr_q <= SEL_W'(NUM_COL - 1);
        end else if (!exStall_i) begin
            vld_q <= do_grant;
            if (do_grant) begin
                sel_q <= pick_idx;
                ptr_q <= pick_idx;
            end
        end
    end

    always_comb begin
        issueValid_o = vld_q & ~exStall_i;
        colGrant_o   = issueValid_o ? (NUM_COL'(1) << sel_q) : '0;
        colSel_o     = sel_q;
        pipeStall_o  = exStall_i;
        busy_o       = (state_q == ST_BUSY) && (cnt_q != '0);
    end
endmodule
